// File: rtl/ccu_isa_dispatch_if.sv
// Instruction-beat stream and per-module config issue bundle of ccu_isa_dispatch.
// The dispatcher is the slave of the beat stream and drives the config side.
interface ccu_isa_dispatch_if #(
   parameter int PORT_WIDTH = 128,
   parameter int NUM_OP     = 4,
   parameter int MAX_BEATS  = 4
);
   logic [PORT_WIDTH-1:0]                  in_dat;
   logic                                   in_vld;
   logic                                   in_rdy;
   logic [NUM_OP-1:0]                      cfg_vld;
   logic [NUM_OP-1:0]                      cfg_rdy;
   logic [NUM_OP*MAX_BEATS*PORT_WIDTH-1:0] cfg_info;

   modport master (output in_dat, in_vld, cfg_rdy, input in_rdy, cfg_vld, cfg_info);
   modport slave  (input in_dat, in_vld, cfg_rdy, output in_rdy, cfg_vld, cfg_info);
endinterface

// File: rtl/ccu_isa_dispatch.sv
// Central ISA dispatcher: assembles multi-beat instructions, queues them per target
// module and issues them over independent valid/ready config handshakes.
module ccu_isa_dispatch #(
   parameter int                  PORT_WIDTH   = 128,
   parameter int                  NUM_OP       = 4,
   parameter int                  MAX_BEATS    = 4,
   parameter logic [4*NUM_OP-1:0] BEATS_PER_OP = 16'h1122,
   parameter int                  FIFO_DEPTH   = 2,
   parameter int                  OPCODE_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ccu_isa_dispatch_if.slave    bus,
   output logic                 err_opcode,
   output logic [NUM_OP-1:0]    fifo_empty,
   output logic [1:0]           mon_state
);
   localparam int W   = MAX_BEATS * PORT_WIDTH;
   localparam int PTW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CTW = $clog2(FIFO_DEPTH + 1);

   // mon_state encoding: IDLE=0, RECV=1, PUSH=2
   typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PUSH = 2'd2} state_t;

   state_t                  state_q;
   logic                    in_rdy_q;
   logic                    err_q;
   logic                    flush_q;
   logic [OPCODE_WIDTH-1:0] op_q;
   logic [3:0]              cnt_q;
   logic [3:0]              nbeats_q;
   logic [W-1:0]            asm_q;
   logic [W-1:0]            mem_q    [NUM_OP][FIFO_DEPTH];
   logic [PTW-1:0]          wr_ptr_q [NUM_OP];
   logic [PTW-1:0]          rd_ptr_q [NUM_OP];
   logic [CTW-1:0]          count_q  [NUM_OP];
   logic [W-1:0]            info_q   [NUM_OP];
   logic [NUM_OP-1:0]       vld_q;

   logic                    accept_s;
   logic                    push_s;
   logic [OPCODE_WIDTH-1:0] op_in_s;
   logic [NUM_OP-1:0]       sel_s;
   logic [NUM_OP-1:0]       full_s;
   logic [NUM_OP-1:0]       push_vec_s;
   logic [NUM_OP-1:0]       flush_vec_s;
   logic [NUM_OP-1:0]       pop_vec_s;

   // Opcodes outside the table never reach the lookup; 0 and 1 both mean single-beat.
   function automatic logic [3:0] beats_of(input logic [OPCODE_WIDTH-1:0] op);
      logic [3:0] n;
      n = 4'd1;
      for (int k = 0; k < NUM_OP; k++) begin
         if (op == OPCODE_WIDTH'(k)) n = BEATS_PER_OP[4*k +: 4];
      end
      return n;
   endfunction

   function automatic logic [PTW-1:0] ptr_inc(input logic [PTW-1:0] p);
      return (p == PTW'(FIFO_DEPTH - 1)) ? {PTW{1'b0}} : p + PTW'(1'b1);
   endfunction

   assign accept_s = bus.in_vld & in_rdy_q;
   assign op_in_s  = bus.in_dat[OPCODE_WIDTH-1:0];

   // Push/pop decisions; a full queue refuses a normal push even if it pops this cycle.
   always_comb begin
      for (int k = 0; k < NUM_OP; k++) begin
         sel_s[k]  = (op_q == OPCODE_WIDTH'(k));
         full_s[k] = (count_q[k] == CTW'(FIFO_DEPTH));
      end
      push_s = (state_q == PUSH) & |(sel_s & (~full_s | {NUM_OP{flush_q}}));
      for (int k = 0; k < NUM_OP; k++) begin
         push_vec_s[k]  = push_s & sel_s[k];
         flush_vec_s[k] = push_vec_s[k] & flush_q;
         pop_vec_s[k]   = (count_q[k] != {CTW{1'b0}}) & (~vld_q[k] | bus.cfg_rdy[k])
                          & ~flush_vec_s[k];
      end
   end

   // Assembly FSM; slot 0 load clears the upper slots so short instructions zero-extend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         in_rdy_q <= 1'b1;
         err_q    <= 1'b0;
         flush_q  <= 1'b0;
         op_q     <= {OPCODE_WIDTH{1'b0}};
         cnt_q    <= 4'd0;
         nbeats_q <= 4'd1;
         asm_q    <= {W{1'b0}};
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  op_q     <= op_in_s;
                  flush_q  <= bus.in_dat[OPCODE_WIDTH];
                  asm_q    <= W'(bus.in_dat);
                  nbeats_q <= beats_of(op_in_s);
                  cnt_q    <= 4'd1;
                  if (op_in_s >= OPCODE_WIDTH'(NUM_OP)) begin
                     err_q <= 1'b1;
                  end else if (beats_of(op_in_s) <= 4'd1) begin
                     state_q  <= PUSH;
                     in_rdy_q <= 1'b0;
                  end else begin
                     state_q <= RECV;
                  end
               end
            end
            RECV: begin
               if (accept_s) begin
                  if (int'(cnt_q) < MAX_BEATS) asm_q[int'(cnt_q)*PORT_WIDTH +: PORT_WIDTH] <= bus.in_dat;
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == nbeats_q - 4'd1) begin
                     state_q  <= PUSH;
                     in_rdy_q <= 1'b0;
                  end
               end
            end
            PUSH: begin
               if (push_s) begin
                  state_q  <= IDLE;
                  in_rdy_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               in_rdy_q <= 1'b1;
            end
         endcase
      end
   end

   // Queue bookkeeping and issue; a flush push restarts the queue holding only the new entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_OP; k++) begin
            wr_ptr_q[k] <= {PTW{1'b0}};
            rd_ptr_q[k] <= {PTW{1'b0}};
            count_q[k]  <= {CTW{1'b0}};
            info_q[k]   <= {W{1'b0}};
            vld_q[k]    <= 1'b0;
         end
      end else begin
         for (int k = 0; k < NUM_OP; k++) begin
            if (flush_vec_s[k]) begin
               rd_ptr_q[k] <= {PTW{1'b0}};
               wr_ptr_q[k] <= ptr_inc({PTW{1'b0}});
               count_q[k]  <= CTW'(1'b1);
            end else begin
               if (push_vec_s[k]) wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
               if (pop_vec_s[k])  rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
               count_q[k] <= count_q[k] + CTW'(push_vec_s[k]) - CTW'(pop_vec_s[k]);
            end
            if (pop_vec_s[k]) begin
               info_q[k] <= mem_q[k][rd_ptr_q[k]];
               vld_q[k]  <= 1'b1;
            end else if (vld_q[k] & bus.cfg_rdy[k]) begin
               vld_q[k] <= 1'b0;
            end
         end
      end
   end

   // Queue storage has no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_OP; k++) begin
         if (push_vec_s[k]) mem_q[k][flush_vec_s[k] ? {PTW{1'b0}} : wr_ptr_q[k]] <= asm_q;
      end
   end

   for (genvar k = 0; k < NUM_OP; k++) begin : g_out
      assign bus.cfg_info[k*W +: W] = info_q[k];
      assign fifo_empty[k]          = (count_q[k] == {CTW{1'b0}});
   end

   assign bus.in_rdy  = in_rdy_q;
   assign bus.cfg_vld = vld_q;
   assign err_opcode  = err_q;
   assign mon_state   = state_q;
endmodule
